// File: rtl/llr_loader.sv
// rtl/llr_loader.sv - channel LLR input stage: quantise, pack and ping-pong frames for ldpc_core
//
// Purpose: accepts beats of P signed soft samples and rounds each one to data_w bits.
//   Rounding is half-up, with an arithmetic right shift by SHIFT. Saturation is symmetric,
//   so the most negative code is never produced.
//   One codeword of R*D samples is packed into one of two frame banks. The completed bank
//   is presented on sig while the other bank fills.
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   in_data         P samples of in_w bits; sample p at [p*in_w +: in_w]
//   in_vld/in_rdy   beat handshake; in_last marks the final beat of a frame
//   sig, sig_vld    presented frame and its valid flag
//   sig_take        consumer pulse that frees the presented frame
//   frame_err       one-cycle pulse on a framing error (early or missing in_last)
//   sat_cnt         clamped-sample count of the presented frame (only with LLR_SAT_CNT_EN)
// Optional feature macro: LLR_SAT_CNT_EN
module llr_loader #(
  parameter int data_w = 5,
  parameter int in_w   = 8,
  parameter int R      = 24,
  parameter int D      = 96,
  parameter int P      = 8,
  parameter int SHIFT  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [P*in_w-1:0]          in_data,
  input  logic                       in_vld,
  output logic                       in_rdy,
  input  logic                       in_last,
  output logic [R*D*data_w-1:0]      sig,
  output logic                       sig_vld,
  input  logic                       sig_take,
  output logic                       frame_err
`ifdef LLR_SAT_CNT_EN
  ,
  output logic [$clog2(R*D+1)-1:0]   sat_cnt
`endif
);

  localparam int BEATS = R*D/P;
  localparam int BW    = P*data_w;
  localparam int FW    = R*D*data_w;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Rounding offset is 2^(SHIFT-1). The integer halving makes it 0 when SHIFT is 0.
  localparam logic signed [in_w:0] RND  = (in_w+1)'((2**SHIFT)/2);
  localparam logic signed [in_w:0] QMAX = (in_w+1)'(2**(data_w-1)-1);
  localparam logic signed [in_w:0] QMIN = -QMAX;

  logic [FW-1:0]          bank0, bank1;
  logic [1:0]             full;
  logic                   wr_bank, rd_bank;
  logic [BCW-1:0]         beat_cnt;

  logic [BW-1:0]          q_beat;
  logic signed [in_w:0]   x, y;
  logic                   acc, last_beat, take;

`ifdef LLR_SAT_CNT_EN
  localparam int CW = $clog2(R*D+1);
  logic [CW-1:0]          beat_sat;
  logic [CW-1:0]          fill_cnt;
  logic [CW-1:0]          sat_reg [2];
`endif

  assign in_rdy    = ~full[wr_bank];
  assign sig_vld   = full[rd_bank];
  assign sig       = rd_bank ? bank1 : bank0;
  assign acc       = in_vld & in_rdy;
  assign last_beat = (beat_cnt == BCW'(BEATS-1));
  assign take      = sig_take & full[rd_bank];

  // Sign-extend to in_w+1 bits before adding the rounding offset, so the add cannot wrap.
  always_comb begin
    q_beat = '0;
    x      = '0;
    y      = '0;
`ifdef LLR_SAT_CNT_EN
    beat_sat = '0;
`endif
    for (int p = 0; p < P; p++) begin
      x = {in_data[p*in_w + in_w-1], in_data[p*in_w +: in_w]};
      y = (x + RND) >>> SHIFT;
      if (y > QMAX) begin
        q_beat[p*data_w +: data_w] = QMAX[data_w-1:0];
`ifdef LLR_SAT_CNT_EN
        beat_sat = beat_sat + CW'(1);
`endif
      end else if (y < QMIN) begin
        q_beat[p*data_w +: data_w] = QMIN[data_w-1:0];
`ifdef LLR_SAT_CNT_EN
        beat_sat = beat_sat + CW'(1);
`endif
      end else begin
        q_beat[p*data_w +: data_w] = y[data_w-1:0];
      end
    end
  end

  // An accepted beat always has full[wr_bank]==0. A valid take always has full[rd_bank]==1.
  // So when both happen in one cycle they address different banks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank0     <= '0;
      bank1     <= '0;
      full      <= 2'b00;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      beat_cnt  <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= acc & (last_beat ? ~in_last : in_last);
      if (take) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
      if (acc) begin
        if (wr_bank) bank1[int'(beat_cnt)*BW +: BW] <= q_beat;
        else         bank0[int'(beat_cnt)*BW +: BW] <= q_beat;
        if (last_beat) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          beat_cnt      <= '0;
        end else if (in_last) begin
          // Early end of frame: drop the partial fill and keep the same bank.
          beat_cnt <= '0;
        end else begin
          beat_cnt <= beat_cnt + BCW'(1);
        end
      end
    end
  end

`ifdef LLR_SAT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt   <= '0;
      sat_reg[0] <= '0;
      sat_reg[1] <= '0;
    end else if (acc) begin
      if (last_beat) begin
        sat_reg[wr_bank] <= fill_cnt + beat_sat;
        fill_cnt         <= '0;
      end else if (in_last) begin
        fill_cnt <= '0;
      end else begin
        fill_cnt <= fill_cnt + beat_sat;
      end
    end
  end

  assign sat_cnt = sat_reg[rd_bank];
`endif

endmodule

// File: tb/tb_llr_loader.sv
// tb/tb_llr_loader.sv - directed self-checking bench for llr_loader
module tb_llr_loader;

  localparam int data_w = 5;
  localparam int in_w   = 8;
  localparam int R      = 24;
  localparam int D      = 96;
  localparam int P      = 8;
  localparam int SHIFT  = 3;
  localparam int NS     = R*D;
  localparam int BEATS  = NS/P;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [P*in_w-1:0]     in_data;
  logic                  in_vld, in_rdy, in_last;
  logic [NS*data_w-1:0]  sig;
  logic                  sig_vld, sig_take, frame_err;
`ifdef LLR_SAT_CNT_EN
  logic [$clog2(NS+1)-1:0] sat_cnt;
`endif

  always #5 clk = ~clk;

  llr_loader #(
    .data_w(data_w), .in_w(in_w), .R(R), .D(D), .P(P), .SHIFT(SHIFT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_vld(in_vld),
    .in_rdy(in_rdy),
    .in_last(in_last),
    .sig(sig),
    .sig_vld(sig_vld),
    .sig_take(sig_take),
    .frame_err(frame_err)
`ifdef LLR_SAT_CNT_EN
    ,
    .sat_cnt(sat_cnt)
`endif
  );

  // Hand-quantised pairs: (x + 4) >>> 3, then clamp to +/-15.
  int in_tbl  [8] = '{16, 127, -128, 4, -5, -13, 3, 100};
  int exp_tbl [8] = '{ 2,  15,  -15, 1, -1,  -2, 0,  13};

  int checks = 0;
  int passes = 0;
  int err_pulses = 0;

  always @(negedge clk) if (frame_err === 1'b1) err_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // mode 0: every sample is 16. mode k>0: table rotated by beat index and k.
  function automatic int samp_in(input int mode, input int b, input int p);
    return (mode == 0) ? 16 : in_tbl[(p + b + mode) % 8];
  endfunction

  function automatic int samp_exp(input int mode, input int b, input int p);
    if (mode < 0) return 0;
    return (mode == 0) ? 2 : exp_tbl[(p + b + mode) % 8];
  endfunction

  function automatic int sig_bad(input int mode);
    int bad = 0;
    for (int i = 0; i < NS; i++) begin
      int e = samp_exp(mode, i / P, i % P);
      logic [data_w-1:0] ev = e[data_w-1:0];
      if (sig[i*data_w +: data_w] !== ev) bad++;
    end
    return bad;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int mode, input int b, input bit last);
    for (int p = 0; p < P; p++) begin
      int v = samp_in(mode, b, p);
      in_data[p*in_w +: in_w] = v[in_w-1:0];
    end
    in_vld  = 1'b1;
    in_last = last;
    tick();
    in_vld  = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic beats(input int mode, input int n);
    for (int b = 0; b < n; b++) beat(mode, b, 1'b0);
  endtask

  initial begin
    int e0;
    rst = 1'b1; in_data = '0; in_vld = 1'b0; in_last = 1'b0; sig_take = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_rdy", in_rdy, 1);
    check("rst_sig_vld", sig_vld, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_sig_zero", sig_bad(-1), 0);
`ifdef LLR_SAT_CNT_EN
    check("rst_sat_cnt", sat_cnt, 0);
`endif

    // A take with nothing presented must be ignored.
    sig_take = 1'b1; tick(); sig_take = 1'b0;
    check("idle_take_vld", sig_vld, 0);
    check("idle_take_rdy", in_rdy, 1);

    // Frame A: all 16 -> all 2.
    e0 = err_pulses;
    beats(0, BEATS-1);
    check("a_vld_before_last", sig_vld, 0);
    beat(0, BEATS-1, 1'b1);
    check("a_vld_after_last", sig_vld, 1);
    check("a_sig", sig_bad(0), 0);
    tick();
    check("a_no_err", err_pulses - e0, 0);
`ifdef LLR_SAT_CNT_EN
    check("a_sat_cnt", sat_cnt, 0);
`endif

    // Frame B back-to-back without take: both banks full.
    beats(1, BEATS-1);
    check("b_rdy_before_last", in_rdy, 1);
    beat(1, BEATS-1, 1'b1);
    check("b_rdy_full", in_rdy, 0);
    check("b_still_a", sig_bad(0), 0);
    sig_take = 1'b1; tick(); sig_take = 1'b0;
    check("b_vld_after_take", sig_vld, 1);
    check("b_sig", sig_bad(1), 0);
    check("b_rdy_after_take", in_rdy, 1);
`ifdef LLR_SAT_CNT_EN
    check("b_sat_cnt", sat_cnt, 2*BEATS);
`endif
    sig_take = 1'b1; tick(); sig_take = 1'b0;
    check("b_vld_drop", sig_vld, 0);

    // Early in_last on beat 100.
    e0 = err_pulses;
    beats(2, 100);
    beat(2, 100, 1'b1);
    check("early_err_pulse", frame_err, 1);
    tick();
    check("early_err_clear", frame_err, 0);
    check("early_vld", sig_vld, 0);
    check("early_pulse_count", err_pulses - e0, 1);
    beats(2, BEATS-1);
    check("c_vld_before_last", sig_vld, 0);
    beat(2, BEATS-1, 1'b1);
    check("c_vld", sig_vld, 1);
    check("c_sig", sig_bad(2), 0);

    // Completion into the other bank coincides with take of the presented one.
    beats(3, BEATS-1);
    sig_take = 1'b1;
    beat(3, BEATS-1, 1'b1);
    sig_take = 1'b0;
    check("d_vld", sig_vld, 1);
    check("d_sig", sig_bad(3), 0);
    check("d_rdy", in_rdy, 1);

    // Asynchronous reset mid-frame while frame D is presented.
    beats(4, 150);
    rst = 1'b1;
    #2;
    check("arst_vld", sig_vld, 0);
    check("arst_rdy", in_rdy, 1);
    check("arst_sig_zero", sig_bad(-1), 0);
    check("arst_err", frame_err, 0);
    tick();
    rst = 1'b0;
    beats(5, BEATS-1);
    check("e_vld_before_last", sig_vld, 0);
    beat(5, BEATS-1, 1'b1);
    check("e_vld", sig_vld, 1);
    check("e_sig", sig_bad(5), 0);

    // A full-length frame with no in_last still completes but flags an error.
    sig_take = 1'b1; tick(); sig_take = 1'b0;
    check("f_vld_drop", sig_vld, 0);
    beats(6, BEATS);
    check("f_err", frame_err, 1);
    check("f_vld", sig_vld, 1);
    check("f_sig", sig_bad(6), 0);
    tick();
    check("f_err_clear", frame_err, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
